// File: rtl/cmp_sort4_ctrl.sv
// Four-word bubble sorter: loads a batch, sorts it in place with one shared
// unsigned comparator (one compare-and-swap per cycle), then drains it smallest first.

module comparator (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        gt,
    output logic        lt,
    output logic        eq
);
    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);
endmodule

module cmp_sort4_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [3:0]       swap_count
);
    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    localparam logic [1:0] LAST      = 2'(DEPTH - 1);
    localparam logic [1:0] LAST_CMP  = 2'(DEPTH - 2);
    localparam logic [1:0] LAST_PASS = 2'(DEPTH - 2);

    state_t           state_q;
    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [1:0]       wr_idx_q;
    logic [1:0]       rd_idx_q;
    logic [1:0]       i_q;
    logic [1:0]       pass_q;
    logic             pass_swap_q;
    logic [3:0]       swap_cnt_q;

    logic [1:0]       i_nxt;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             cmp_eq;

    assign i_nxt = i_q + 2'd1;
    assign cmp_a = buf_q[i_q];
    assign cmp_b = buf_q[i_nxt];

    comparator u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .gt (cmp_gt),
        .lt (cmp_lt),
        .eq (cmp_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            buf_q       <= '{default: '0};
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            i_q         <= '0;
            pass_q      <= '0;
            pass_swap_q <= 1'b0;
            swap_cnt_q  <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        buf_q[wr_idx_q] <= in_data;
                        wr_idx_q        <= wr_idx_q + 2'd1;
                        if (wr_idx_q == LAST) begin
                            state_q     <= SORT;
                            swap_cnt_q  <= '0;
                            pass_q      <= '0;
                            i_q         <= '0;
                            pass_swap_q <= 1'b0;
                        end
                    end
                end
                SORT: begin
                    // Swap only on strictly greater so equal words keep their order.
                    if (cmp_gt) begin
                        buf_q[i_q]   <= cmp_b;
                        buf_q[i_nxt] <= cmp_a;
                        swap_cnt_q   <= swap_cnt_q + 4'd1;
                        pass_swap_q  <= 1'b1;
                    end
                    if (i_q == LAST_CMP) begin
                        if (!(pass_swap_q || cmp_gt) || pass_q == LAST_PASS) begin
                            state_q  <= DRAIN;
                            rd_idx_q <= '0;
                        end else begin
                            pass_q      <= pass_q + 2'd1;
                            i_q         <= '0;
                            pass_swap_q <= 1'b0;
                        end
                    end else begin
                        i_q <= i_nxt;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        rd_idx_q <= rd_idx_q + 2'd1;
                        if (rd_idx_q == LAST) begin
                            state_q  <= LOAD;
                            wr_idx_q <= '0;
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign in_ready   = (state_q == LOAD);
    assign out_valid  = (state_q == DRAIN);
    assign busy       = (state_q != LOAD);
    assign out_data   = buf_q[rd_idx_q];
    assign swap_count = swap_cnt_q;

endmodule

// File: tb/tb_cmp_sort4_ctrl.sv
// Directed bench for cmp_sort4_ctrl: loads fixed batches, checks sort latency,
// swap count, drain order, back-pressure, ignored input pulses and async reset.

module tb_cmp_sort4_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;
    logic [3:0]  swap_count;

    int n_checks = 0;
    int n_pass   = 0;

    cmp_sort4_ctrl #(.WIDTH(16), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .swap_count (swap_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic run_batch(input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3,
                             input logic [15:0] x0, input logic [15:0] x1,
                             input logic [15:0] x2, input logic [15:0] x3,
                             input int n_exp, input int sc_exp,
                             input int stall_at, input bit pulse);
        logic [15:0] din [4];
        logic [15:0] xp  [4];
        int n;
        din = '{d0, d1, d2, d3};
        xp  = '{x0, x1, x2, x3};
        for (int k = 0; k < 4; k++) begin
            check("load_ready", in_ready, 1);
            in_valid = 1'b1;
            in_data  = din[k];
            @(posedge clk); #1;
        end
        in_valid = pulse;
        in_data  = 16'h0055;
        check("sort_in_ready", in_ready, 0);
        check("sort_busy", busy, 1);
        check("sort_out_valid", out_valid, 0);
        check("sort_swap_clr", swap_count, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            n++;
        end
        check("sort_latency", n, n_exp);
        check("swap_count", swap_count, sc_exp);
        check("drain_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, xp[k]);
                    check("stall_in_ready", in_ready, 0);
                    in_valid = pulse;
                    @(posedge clk); #1;
                end
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            check("drain_valid", out_valid, 1);
            check("drain_data", out_data, xp[k]);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check("done_in_ready", in_ready, 1);
        check("done_out_valid", out_valid, 0);
        check("done_busy", busy, 0);
        check("swap_hold", swap_count, sc_exp);
    endtask

    initial begin
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_swap", swap_count, 0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        run_batch(16'd5, 16'd3, 16'd9, 16'd1, 16'd1, 16'd3, 16'd5, 16'd9, 9, 4, -1, 1'b0);
        run_batch(16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd2, 16'd3, 16'd4, 3, 0, -1, 1'b0);
        run_batch(16'd2, 16'd1, 16'd3, 16'd4, 16'd1, 16'd2, 16'd3, 16'd4, 6, 1, -1, 1'b0);
        run_batch(16'hFFFF, 16'h8000, 16'h0001, 16'h0000,
                  16'h0000, 16'h0001, 16'h8000, 16'hFFFF, 9, 6, -1, 1'b0);
        run_batch(16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 3, 0, 1, 1'b1);

        // Start 4,3,2,1 and reset two compares into the sort.
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(4 - k);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        check("midsort_busy", busy, 1);
        check("midsort_swaps", swap_count, 2);
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_out_data", out_data, 0);
        check("arst_swap", swap_count, 0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        run_batch(16'd4, 16'd3, 16'd2, 16'd1, 16'd1, 16'd2, 16'd3, 16'd4, 9, 6, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cmp_sort4_ctrl.md
CMP_SORT4_CTRL -- requirements
Module: cmp_sort4_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, data word width; only 16 is supported.
REQ-002 Parameter DEPTH, default 4, words per sort batch; only 4 is supported.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data is valid.
REQ-006 in_ready  output  1  block accepts a word; high only in state LOAD.
REQ-007 in_data  input  16  unsigned word to load.
REQ-008 out_valid  output  1  out_data is valid; high only in state DRAIN.
REQ-009 out_ready  input  1  consumer accepts out_data.
REQ-010 out_data  output  16  sorted word, smallest first.
REQ-011 busy  output  1  high in SORT and DRAIN.
REQ-012 swap_count  output  4  number of swaps performed in the most recent sort (0..6).

Function
REQ-013 The block SHALL instantiate the team's 16-bit unsigned comparator (module comparator: a, b, gt, lt, eq) exactly once, and SHALL share that instance across all compare steps.
REQ-014 The state machine SHALL have three states: LOAD, SORT and DRAIN.
REQ-015 In LOAD, each edge with in_valid && in_ready SHALL write in_data to buf[wr_idx] and increment wr_idx.
REQ-016 The edge that accepts the 4th word SHALL:
- move the state to SORT;
- clear swap_count, the pass index, the compare index i and the pass-swap flag.
REQ-017 In SORT, each cycle SHALL perform one compare-and-swap, with comparator a=buf[i] and b=buf[i+1]:
- if gt, buf[i] and buf[i+1] SHALL be exchanged at the edge, swap_count SHALL increment and the pass-swap flag SHALL be set;
- if eq or lt, nothing SHALL change, which keeps the sort stable.
REQ-018 Index i SHALL step 0,1,2 within a pass; after i=2 a pass SHALL be complete.
REQ-019 At pass completion:
- if the pass had no swap, or 3 passes are done, the state SHALL move to DRAIN with rd_idx=0;
- otherwise a new pass SHALL start with i=0 and the pass-swap flag cleared.
REQ-020 SORT latency SHALL be N cycles, where N = number of compares, 3 <= N <= 9.
- out_valid SHALL be high after edge E0+N, where E0 is the edge that accepted the 4th word.
REQ-021 In DRAIN, out_data SHALL equal buf[rd_idx].
- Each edge with out_valid && out_ready SHALL increment rd_idx.
- The 4th transfer SHALL return the state to LOAD with wr_idx=0.
REQ-022 While out_valid is high and out_ready is low, out_data SHALL hold stable and no word SHALL be lost or repeated.
REQ-023 in_ready SHALL depend on state only, and out_valid SHALL depend on state only; there SHALL be no combinational path from in_valid or out_ready.
REQ-024 in_valid asserted outside LOAD SHALL be ignored, with no buffer or index change.
REQ-025 swap_count SHALL hold its value from the end of SORT until the next entry into SORT.
REQ-026 Comparison SHALL be unsigned: 0x8000 > 0x7FFF.

Reset
REQ-027 rst_n low SHALL, immediately and independent of clk:
- set state to LOAD;
- set wr_idx, rd_idx, i and the pass counter to 0;
- set buf[0..3] to 0;
- set out_data=0, out_valid=0, busy=0, swap_count=0 and in_ready=1.
REQ-028 Reset during LOAD, SORT or DRAIN SHALL discard the batch; after release, the next accepted word SHALL be buf[0].
REQ-029 The first accept SHALL occur no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-030 Load 5,3,9,1 -> out 1,3,5,9; swap_count=4; N=9.
REQ-031 Load 1,2,3,4 -> out 1,2,3,4; swap_count=0; out_valid high after E0+3.
REQ-032 Load 2,1,3,4 -> out 1,2,3,4; swap_count=1; N=6 (early exit after pass 2).
REQ-033 Load 0xFFFF,0x8000,0x0001,0x0000 -> out 0x0000,0x0001,0x8000,0xFFFF; swap_count=6; N=9.
REQ-034 Load 7,7,7,7; hold out_ready low 5 cycles at the 2nd word; pulse in_valid during SORT and DRAIN -> out 7,7,7,7 with out_data stable while stalled; swap_count=0; in_ready stays 0 during SORT and DRAIN; pulses ignored.
REQ-035 Assert rst_n low mid-SORT -> outputs take reset values immediately. After release, load 4,3,2,1 -> out 1,2,3,4; swap_count=6.
